// File: rtl/uart_rx.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote at mid-bit,
// one-cycle strobes for good bytes and framing errors.
module uart_rx #(
    parameter int baud_div  = 434,
    parameter int cnt_width = 9
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    output logic [7:0] rx_dat,
    output logic       rx_vld,
    output logic       frame_err,
    output logic       busy
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        START     = 3'd1,
        DATA      = 3'd2,
        STOP      = 3'd3,
        WAIT_HIGH = 3'd4
    } state_t;

    localparam int HALF = baud_div / 2;
    localparam logic [cnt_width-1:0] CNT_LAST = cnt_width'(baud_div - 1);
    localparam logic [cnt_width-1:0] SAMP_A   = cnt_width'(HALF - 1);
    localparam logic [cnt_width-1:0] SAMP_B   = cnt_width'(HALF);
    localparam logic [cnt_width-1:0] DECIDE   = cnt_width'(HALF + 1);

    state_t               state, state_next;
    logic [1:0]           sync;
    logic                 rx_s;
    logic [cnt_width-1:0] cnt;
    logic [2:0]           bit_idx;
    logic                 samp_a, samp_b;
    logic                 maj;
    logic                 at_decide, at_last;
    logic [7:0]           shreg;
    logic                 shift_en, load_dat, flag_err;

    // Both flops reset high so reset never looks like a start bit.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= 2'b11;
        else        sync <= {sync[0], rx};
    end

    assign rx_s      = sync[1];
    assign at_decide = (cnt == DECIDE);
    assign at_last   = (cnt == CNT_LAST);
    // Third vote is the live sample at the decision cycle.
    assign maj       = (samp_a & samp_b) | (samp_a & rx_s) | (samp_b & rx_s);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:      if (!rx_s) state_next = START;
            START: begin
                if (at_decide && maj) state_next = IDLE;
                else if (at_last)     state_next = DATA;
            end
            DATA:      if (at_last && bit_idx == 3'd7) state_next = STOP;
            STOP:      if (at_decide) state_next = maj ? IDLE : WAIT_HIGH;
            WAIT_HIGH: if (rx_s) state_next = IDLE;
            default:   state_next = IDLE;
        endcase
    end

    always_comb begin
        shift_en = (state == DATA) && at_decide;
        load_dat = (state == STOP) && at_decide && maj;
        flag_err = (state == STOP) && at_decide && !maj;
        busy     = (state != IDLE);
    end

    // Counter is parked at 0 outside a frame so START begins its bit at cnt 0.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (state == IDLE || state == WAIT_HIGH ||
                     state_next == IDLE || state_next == WAIT_HIGH) begin
            cnt <= '0;
        end else if (at_last) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + cnt_width'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)              bit_idx <= 3'd0;
        else if (state != DATA)  bit_idx <= 3'd0;
        else if (at_last)        bit_idx <= bit_idx + 3'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            samp_a <= 1'b1;
            samp_b <= 1'b1;
        end else begin
            if (cnt == SAMP_A) samp_a <= rx_s;
            if (cnt == SAMP_B) samp_b <= rx_s;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)        shreg <= 8'h00;
        else if (shift_en) shreg[bit_idx] <= maj;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_dat    <= 8'h00;
            rx_vld    <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_vld    <= load_dat;
            frame_err <= flag_err;
            if (load_dat) rx_dat <= shreg;
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: a fast instance (baud_div 16) for directed
// frames and a default instance fed by a 432-clk-bit transmitter model.
module tb_uart_rx;

    localparam int BD  = 16;
    localparam int TX2 = 432;

    typedef struct {
        bit         err;
        logic [7:0] dat;
        longint     cyc;
    } exp_t;

    logic       clk = 1'b0;
    logic       rst_n1, rst_n2, rx1, rx2;
    logic [7:0] rx_dat1, rx_dat2;
    logic       rx_vld1, rx_vld2, frame_err1, frame_err2, busy1, busy2;

    exp_t       q1[$];
    exp_t       q2[$];
    int         n_vec = 0;
    int         n_bad = 0;
    longint     cyc = 0;
    logic [7:0] held1 = 8'h00;

    always #10 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    uart_rx #(.baud_div(BD), .cnt_width(5)) dut1 (
        .clk(clk), .rst_n(rst_n1), .rx(rx1), .rx_dat(rx_dat1),
        .rx_vld(rx_vld1), .frame_err(frame_err1), .busy(busy1)
    );

    uart_rx dut2 (
        .clk(clk), .rst_n(rst_n2), .rx(rx2), .rx_dat(rx_dat2),
        .rx_vld(rx_vld2), .frame_err(frame_err2), .busy(busy2)
    );

    task automatic chk(input string name, input longint act, input longint exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h)", name, act, act, exp, exp);
        end
    endtask

    task automatic mon(input int id, input logic vld, input logic err, input logic [7:0] dat);
        exp_t e;
        chk($sformatf("dut%0d_strobe_exclusive", id), longint'(vld & err), 0);
        if ((id == 1 && q1.size() == 0) || (id == 2 && q2.size() == 0)) begin
            n_vec++;
            n_bad++;
            $display("FAIL dut%0d_unexpected_strobe: vld=%0b err=%0b dat=%02h at cyc %0d, none expected",
                     id, vld, err, dat, cyc);
            return;
        end
        if (id == 1) e = q1.pop_front();
        else         e = q2.pop_front();
        chk($sformatf("dut%0d_kind_err", id), longint'(err), longint'(e.err));
        chk($sformatf("dut%0d_rx_dat", id), longint'(dat), longint'(e.dat));
        if (e.cyc >= 0) chk($sformatf("dut%0d_strobe_edge", id), cyc, e.cyc);
    endtask

    always @(negedge clk) begin
        if (rx_vld1 === 1'b1 || frame_err1 === 1'b1) mon(1, rx_vld1, frame_err1, rx_dat1);
        if (rx_vld2 === 1'b1 || frame_err2 === 1'b1) mon(2, rx_vld2, frame_err2, rx_dat2);
    end

    // Called at a negedge; start bit edge T0 is the next posedge, so the
    // strobe is visible at the negedge numbered cyc + 1 + 156.
    task automatic frame1(input logic [7:0] b, input bit stop, input int glitch_bit, input bit timed);
        logic [9:0] fr;
        longint     t;
        fr = {stop, b, 1'b0};
        t  = timed ? cyc + 157 : -1;
        if (stop) begin
            q1.push_back(exp_t'{1'b0, b, t});
            held1 = b;
        end else begin
            q1.push_back(exp_t'{1'b1, held1, t});
        end
        for (int i = 0; i < 10; i++) begin
            for (int j = 0; j < BD; j++) begin
                rx1 = fr[i] ^ ((i == glitch_bit + 1) && (j == BD / 2));
                @(negedge clk);
            end
        end
    endtask

    task automatic frame2(input logic [7:0] b);
        logic [9:0] fr;
        fr = {1'b1, b, 1'b0};
        q2.push_back(exp_t'{1'b0, b, -1});
        for (int i = 0; i < 10; i++) begin
            rx2 = fr[i];
            repeat (TX2) @(negedge clk);
        end
    endtask

    task automatic idle1(input int n);
        rx1 = 1'b1;
        repeat (n) @(negedge clk);
    endtask

    initial begin
        logic [7:0] lb [12];
        logic [9:0] part;
        lb = '{8'h00, 8'hFF, 8'h55, 8'hAA, 8'h01, 8'h80,
               8'h7E, 8'h81, 8'h3C, 8'hC3, 8'h0F, 8'hF0};
        rx1 = 1'b1; rx2 = 1'b1;
        rst_n1 = 1'b0; rst_n2 = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_rx_dat1", rx_dat1, 8'h00);
        chk("reset_rx_vld1", rx_vld1, 0);
        chk("reset_frame_err1", frame_err1, 0);
        chk("reset_busy1", busy1, 0);
        chk("reset_busy2", busy2, 0);
        chk("reset_rx_dat2", rx_dat2, 8'h00);
        rst_n1 = 1'b1; rst_n2 = 1'b1;
        @(negedge clk);
        fork
            begin
                idle1(4);
                frame1(8'hA5, 1'b1, -1, 1'b1);
                idle1(16);
                frame1(8'h00, 1'b1, -1, 1'b1);
                frame1(8'hFF, 1'b1, -1, 1'b1);
                frame1(8'h55, 1'b1, -1, 1'b1);
                idle1(16);
                frame1(8'h3C, 1'b0, -1, 1'b1);
                idle1(32);
                chk("rx_dat_held_after_err", rx_dat1, 8'h55);
                // Short low pulse: detected as a start, then rejected.
                rx1 = 1'b0;
                repeat (3) @(negedge clk);
                chk("glitch_busy_rise", busy1, 1);
                idle1(13);
                chk("glitch_busy_fall", busy1, 0);
                idle1(16);
                frame1(8'h00, 1'b1, 3, 1'b1);
                idle1(16);
                // Break: 40 bit times low gives a single framing error.
                q1.push_back(exp_t'{1'b1, held1, cyc + 157});
                rx1 = 1'b0;
                repeat (40 * BD) @(negedge clk);
                chk("break_busy_wait_high", busy1, 1);
                idle1(32);
                chk("break_busy_idle", busy1, 0);
                frame1(8'h81, 1'b1, -1, 1'b1);
                idle1(16);
                // Abort 8'h7E mid data bit 4.
                part = {1'b1, 8'h7E, 1'b0};
                for (int i = 0; i < 6; i++) begin
                    for (int j = 0; j < BD; j++) begin
                        if (i == 5 && j == BD / 2) break;
                        rx1 = part[i];
                        @(negedge clk);
                    end
                end
                rst_n1 = 1'b0;
                rx1 = 1'b1;
                repeat (2) @(negedge clk);
                chk("midreset_rx_dat", rx_dat1, 8'h00);
                chk("midreset_rx_vld", rx_vld1, 0);
                chk("midreset_frame_err", frame_err1, 0);
                chk("midreset_busy", busy1, 0);
                rst_n1 = 1'b1;
                held1 = 8'h00;
                idle1(48);
                frame1(8'h7E, 1'b1, -1, 1'b1);
                idle1(16);
            end
            begin
                repeat (10) @(negedge clk);
                foreach (lb[i]) frame2(lb[i]);
                rx2 = 1'b1;
                repeat (TX2) @(negedge clk);
            end
        join
        repeat (20) @(negedge clk);
        chk("dut1_queue_drained", q1.size(), 0);
        chk("dut2_queue_drained", q2.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        repeat (80000) @(posedge clk);
        n_bad++;
        $display("FAIL watchdog: run still active at cyc %0d, limit 80000", cyc);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $fatal(1, "watchdog expired");
    end

endmodule

// File: doc/uart_rx.md
# uart_rx

UART receiver that samples an asynchronous serial line and delivers complete bytes to the fabric. It is the receive-side counterpart of the UART transmitter: 8 data bits, LSB first, 1 start bit, 1 stop bit, no parity. It shares the 50 MHz system clock and outputs a one-cycle strobe per good byte. Framing errors are flagged rather than delivered as data.

## Interface
- `baud_div`, default 434: clk cycles per bit; 434 gives 115200 bps at 50 MHz. Legal range 8..511.
- `cnt_width`, default 9: width of the bit-period counter; must satisfy 2^cnt_width > baud_div.
- `clk`  input  1  system clock, 50 MHz.
- `rst_n`  input  1  reset, asynchronous, active-low.
- `rx`  input  1  serial line, asynchronous to clk, idle high.
- `rx_dat`  output  8  last correctly framed byte; holds its value between frames.
- `rx_vld`  output  1  one-cycle strobe; `rx_dat` is new in the same cycle.
- `frame_err`  output  1  one-cycle strobe; the stop bit was sampled low.
- `busy`  output  1  high whenever the state is not IDLE.

## Operation
- **Synchronizer:** `rx` passes through 2 flops, giving `rx_s`. Both flops reset to 1. All logic uses `rx_s` only.
- **Definitions:** half = baud_div/2, using integer division. `cnt` counts 0..baud_div-1 in every bit period and wraps to 0.
- **Sampling:** `rx_s` is captured at cnt = half-1, half and half+1. The bit value is the 2-of-3 majority, decided at the cnt = half+1 edge (the "decision").
- **IDLE:**
  - `cnt` = 0 and `bit_idx` = 0.
  - If `rx_s` = 0, go to START.
- **START:**
  - At the decision, a majority of 1 is a false start: return to IDLE with no strobe.
  - Otherwise, at cnt = baud_div-1, go to DATA with `bit_idx` = 0.
- **DATA:**
  - At the decision, the majority bit shifts into the shift register at bit position `bit_idx` (LSB first).
  - At cnt = baud_div-1, `bit_idx` increments. After `bit_idx` 7, go to STOP.
- **STOP** (acts at the decision, without waiting for the end of the stop bit):
  - Majority 1: `rx_dat` <= shift register, `rx_vld` = 1 for one cycle, then go to IDLE.
  - Majority 0: `frame_err` = 1 for one cycle, `rx_dat` unchanged, then go to WAIT_HIGH.
- **WAIT_HIGH:** remain until `rx_s` = 1, then go to IDLE. This prevents a break condition (line held low) from being read as repeated frames.
- **Strobes:** `rx_vld` and `frame_err` are never high in the same cycle.
- **Reset values:**
  - `rx_dat` = 8'h00, `rx_vld` = 0, `frame_err` = 0, `busy` = 0.
  - State = IDLE, `cnt` = 0, shift register = 0.
- **Reset mid-frame:** abandons the frame immediately. No strobe is produced, and reception resumes on the next start bit after reset is released.

## Timing
- **Reference edge:** T0 is the clk edge at which the first synchronizer flop captures the start bit's 0.
- **Early edges:** `rx_s` goes low after edge T0+1. The state enters START at edge T0+2, and `busy` rises at that edge.
- **Strobe edge:** `rx_vld` (or `frame_err`) rises at edge T0 + 9·baud_div + half + 4 and stays high for exactly one cycle.
  - Default parameters: T0+4127.
  - baud_div = 16: T0+156.
- **Return to IDLE:** at the same edge as the strobe, for a good stop bit. `busy` falls at that edge.
- **Back-to-back frames:** a start bit immediately following a stop bit is accepted. IDLE is reached about half a bit period before the next falling edge.
- **Drift tolerance:** the receiver accepts a sender whose bit period differs by up to ±4% from baud_div. This covers the transmitter's 2×216 = 432-clock bit against baud_div 434.
- **Throughput:** one byte per 10·baud_div clk cycles.

## Test plan
- **Single byte:** baud_div = 16, drive the frame for 8'hA5 with 16-clk bits → `rx_vld` high for one cycle at T0+156, `rx_dat` = 8'hA5, `frame_err` stays 0.
- **Back-to-back bytes:** send 8'h00, 8'hFF, 8'h55 with no gaps → exactly 3 `rx_vld` pulses, 160 clk apart, with `rx_dat` = 00, FF, 55 in order.
- **Glitch rejection:**
  - A 3-clk low pulse on idle `rx` → no strobe, and `busy` returns to 0 within 16 clk.
  - A single-clk 1 glitch at the mid-point of data bit 3 of 8'h00 → `rx_dat` = 8'h00.
- **Frame error and break:**
  - Frame 8'h3C with the stop bit held low → `frame_err` pulse, no `rx_vld`, `rx_dat` keeps its previous value.
  - Line held low for 40 bits → exactly one `frame_err` pulse; the next valid frame 8'h81 is received correctly.
- **Reset mid-frame:** assert `rst_n` low during data bit 4, release, then send 8'h7E → no strobe for the aborted frame, all outputs at reset values, then a correct `rx_vld` with 8'h7E.
- **Loopback:** 50 MHz, transmitter at half-period 216 driving `rx`, receiver at baud_div 434, 256 consecutive bytes 8'h00..8'hFF → 256 `rx_vld` pulses with matching data and no `frame_err`.
